// File: rtl/dmi_req_buffer.sv
// dmi_req_buffer: N-entry circular buffer on the DMI request path.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   flush_i                           sync clear of all held entries
//   dmi_req_i/_valid_i/_ready_o       upstream request handshake
//   dmi_req_o/_valid_o/_ready_i       downstream request handshake
//   usage_o, full_o, empty_o          fill level and status flags
// Option: define DMI_REQ_BUF_FALLTHROUGH_EN for zero-latency pass-through
// when the buffer is empty (adds a valid_i -> valid_o path).

package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;
endpackage

module dmi_req_buffer #(
    parameter int unsigned  DEPTH = 2,
    parameter type          T     = dm::dmi_req_t,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  T                 dmi_req_i,
    input  logic             dmi_req_valid_i,
    output logic             dmi_req_ready_o,
    output T                 dmi_req_o,
    output logic             dmi_req_valid_o,
    input  logic             dmi_req_ready_i,
    output logic [CNT_W-1:0] usage_o,
    output logic             full_o,
    output logic             empty_o
);

    // A one-entry buffer still needs a 1-bit pointer.
    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == MAX_CNT);
    assign usage_o = count;
    assign full_o  = full;
    assign empty_o = empty;

    // Ready depends only on registered state and flush, never on ready_i.
    assign dmi_req_ready_o = !full && !flush_i;

`ifdef DMI_REQ_BUF_FALLTHROUGH_EN
    logic bypass;

    // Empty buffer forwards the request straight through; it is only
    // stored when downstream does not take it in the same cycle.
    assign bypass          = empty && !flush_i
                             && dmi_req_valid_i && dmi_req_ready_i;
    assign dmi_req_valid_o = !flush_i && (!empty || dmi_req_valid_i);
    assign dmi_req_o       = empty ? dmi_req_i : mem[rd_ptr];
    assign push            = dmi_req_valid_i && dmi_req_ready_o && !bypass;
    assign pop             = !empty && !flush_i && dmi_req_ready_i;
`else
    assign dmi_req_valid_o = !empty && !flush_i;
    assign dmi_req_o       = mem[rd_ptr];
    assign push            = dmi_req_valid_i && dmi_req_ready_o;
    assign pop             = dmi_req_valid_o && dmi_req_ready_i;
`endif

    // Storage is deliberately not reset; only control state is.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= dmi_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmi_req_buffer.sv
// tb_dmi_req_buffer: scoreboard bench for dmi_req_buffer.
// Main instance DEPTH=3, streaming instance DEPTH=2.

module tb_dmi_req_buffer;

    typedef dm::dmi_req_t req_t;

`ifdef DMI_REQ_BUF_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic       flush = 1'b0;
    logic       vin   = 1'b0;
    logic       rin   = 1'b0;
    req_t       din   = '0;
    req_t       dout;
    logic       vout;
    logic       rout;
    logic       full;
    logic       empty;
    logic [1:0] usage;

    logic       flush2 = 1'b0;
    logic       v2     = 1'b0;
    logic       r2     = 1'b0;
    req_t       d2     = '0;
    req_t       dout2;
    logic       vout2;
    logic       rout2;
    logic       full2;
    logic       empty2;
    logic [1:0] usage2;

    dmi_req_buffer #(.DEPTH(3)) u_dut3 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .dmi_req_i       (din),
        .dmi_req_valid_i (vin),
        .dmi_req_ready_o (rout),
        .dmi_req_o       (dout),
        .dmi_req_valid_o (vout),
        .dmi_req_ready_i (rin),
        .usage_o         (usage),
        .full_o          (full),
        .empty_o         (empty)
    );

    dmi_req_buffer #(.DEPTH(2)) u_dut2 (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush2),
        .dmi_req_i       (d2),
        .dmi_req_valid_i (v2),
        .dmi_req_ready_o (rout2),
        .dmi_req_o       (dout2),
        .dmi_req_valid_o (vout2),
        .dmi_req_ready_i (r2),
        .usage_o         (usage2),
        .full_o          (full2),
        .empty_o         (empty2)
    );

    int   checks = 0;
    int   fails  = 0;
    req_t sb[$];
    int   n2     = 0;
    int   rec_n;
    logic rec_rdy;
    req_t exp_q;
    logic held;
    logic pv = 1'b0;
    logic pr = 1'b0;
    req_t pd = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t rnd();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[40:0];
    endfunction

    task automatic drive(input logic v, input req_t d, input logic r,
                         input logic f);
        @(posedge clk);
        #1;
        vin   = v;
        din   = d;
        rin   = r;
        flush = f;
    endtask

    // Reference model: the queue holds the requests accepted but not yet
    // delivered; status flags and handshakes follow from its size.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            rec_n   = sb.size();
            rec_rdy = (rec_n < 3) && !flush;
            chk("usage", 64'(usage), 64'(rec_n));
            chk("full", 64'(full), 64'(rec_n == 3));
            chk("empty", 64'(empty), 64'(rec_n == 0));
            chk("ready", 64'(rout), 64'(rec_rdy));
            chk("valid", 64'(vout),
                64'((rec_n > 0 || (FT && vin)) && !flush));
            if (flush) begin
                sb.delete();
            end else if (vin && rec_rdy) begin
                sb.push_back(din);
            end
        end
    end

    // Output monitor for the main instance.
    always @(negedge clk) begin
        #1;
        if (rst_n && vout && rin) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_out: got %0h expected none", dout);
            end else begin
                exp_q = sb.pop_front();
                chk("data", 64'(dout), 64'(exp_q));
            end
        end
    end

    // Output monitor for the streaming instance.
    always @(negedge clk) begin
        #1;
        if (rst_n && vout2 && r2) begin
            chk("stream_data", 64'(dout2.data), 64'(n2));
            n2++;
        end
    end

    // Upstream must keep the payload stable while stalled.
    always @(negedge clk) begin
        if (rst_n && pv && !pr && vin) begin
            assert (din == pd)
            else $error("request payload changed while stalled");
        end
        pv = vin && rst_n;
        pr = rout;
        pd = din;
    end

    initial begin
        req_t a;
        req_t b;
        req_t c;
        req_t d;
        req_t f5;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(vout), 64'(0));
        chk("rst_ready", 64'(rout), 64'(1));
        chk("rst_usage", 64'(usage), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst2_usage", 64'(usage2), 64'(0));
        rst_n = 1'b1;

        // Async reset with two entries held.
        drive(1'b1, rnd(), 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        chk("pre_rst_usage", 64'(usage), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(vout), 64'(0));
        chk("arst_ready", 64'(rout), 64'(1));
        chk("arst_usage", 64'(usage), 64'(0));
        chk("arst_empty", 64'(empty), 64'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fill to DEPTH, hold off a fourth, then drain in order.
        a = rnd();
        b = rnd();
        c = rnd();
        d = rnd();
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        drive(1'b1, c, 1'b0, 1'b0);
        drive(1'b1, d, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_ready", 64'(rout), 64'(0));
        chk("fill_usage", 64'(usage), 64'(3));
        drive(1'b1, d, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("fill_held", 64'(usage), 64'(3));
        drive(1'b1, d, 1'b1, 1'b0);
        drive(1'b1, d, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            if (empty) break;
        end
        chk("drain_empty", 64'(empty), 64'(1));
        chk("drain_sb", 64'(sb.size()), 64'(0));
        drive(1'b0, '0, 1'b0, 1'b0);

        // Streaming on the DEPTH=2 instance.
        r2 = 1'b1;
        for (int k = 0; k < 21; k++) begin
            @(posedge clk);
            #1;
            v2      = (k < 20);
            d2      = '0;
            d2.data = 32'(k);
            @(negedge clk);
            #2;
            chk("stream_usage", 64'(usage2),
                64'((k == 0 || FT) ? 0 : 1));
        end
        chk("stream_count", 64'(n2), 64'(20));
        v2 = 1'b0;
        r2 = 1'b0;

        // Flush with two entries held and a push+pop attempted.
        drive(1'b1, rnd(), 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b0, 1'b0);
        drive(1'b1, rnd(), 1'b1, 1'b1);
        @(negedge clk);
        #2;
        chk("flush_valid", 64'(vout), 64'(0));
        chk("flush_ready", 64'(rout), 64'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        chk("post_flush_usage", 64'(usage), 64'(0));
        chk("post_flush_empty", 64'(empty), 64'(1));
        drive(1'b0, '0, 1'b1, 1'b0);

        // Latency from an empty buffer.
        f5      = '0;
        f5.data = 32'h5A;
`ifdef DMI_REQ_BUF_FALLTHROUGH_EN
        drive(1'b1, f5, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        chk("ft_valid", 64'(vout), 64'(1));
        chk("ft_data", 64'(dout.data), 64'h5A);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("ft_usage0", 64'(usage), 64'(0));
        drive(1'b1, f5, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        chk("ft_usage1", 64'(usage), 64'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
`else
        drive(1'b1, f5, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        chk("lat_valid0", 64'(vout), 64'(0));
        drive(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        chk("lat_valid1", 64'(vout), 64'(1));
        chk("lat_data", 64'(dout.data), 64'h5A);
        chk("lat_usage", 64'(usage), 64'(1));
`endif
        drive(1'b0, '0, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            held = vin && !rout;
            @(posedge clk);
            #1;
            rin   = ($urandom_range(99) < 60);
            flush = ($urandom_range(99) < 2);
            if (!held) begin
                vin = ($urandom_range(99) < 60);
                din = rnd();
            end
        end

        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        chk("final_sb", 64'(sb.size()), 64'(0));
        chk("final_empty", 64'(empty), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
